// File: rtl/clk_enable_gen_pkg.sv
// Shared constants and helpers for the fractional clock-enable generator.
package clk_enable_gen_pkg;

   localparam int CHANNELS_DEFAULT = 2;
   localparam int ACC_W_DEFAULT    = 16;
   localparam int DEF_INC_DEFAULT  = 1;
   localparam int DEF_MOD_DEFAULT  = 5;

   // Channel-index width; a single channel still gets a 1-bit select.
   function automatic int idx_w(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/clk_enable_chan.sv
// One phase-accumulator channel: emits ce at f_clk * inc / mod with no drift.
module clk_enable_chan #(
   parameter int ACC_W   = 16,
   parameter int DEF_INC = 1,
   parameter int DEF_MOD = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             restart,
   input  logic [ACC_W-1:0] cfg_inc,
   input  logic [ACC_W-1:0] cfg_mod,
   output logic             ce,
   output logic             clk_out
);

   logic [ACC_W-1:0] inc;
   logic [ACC_W-1:0] mod;
   logic [ACC_W-1:0] acc;
   logic [ACC_W:0]   sum;
   logic [ACC_W:0]   acc_nxt;
   logic             wrap;

   // One extra bit keeps acc + inc exact before the modulus compare.
   always_comb begin
      sum     = {1'b0, acc} + {1'b0, inc};
      wrap    = (inc != '0) && (sum >= {1'b0, mod});
      acc_nxt = wrap ? (sum - {1'b0, mod}) : sum;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         inc     <= ACC_W'(DEF_INC);
         mod     <= ACC_W'(DEF_MOD);
         acc     <= '0;
         ce      <= 1'b0;
         clk_out <= 1'b0;
      end else if (load) begin
         inc     <= cfg_inc;
         mod     <= cfg_mod;
         acc     <= '0;
         ce      <= 1'b0;
         clk_out <= 1'b0;
      end else if (restart) begin
         acc     <= '0;
         ce      <= 1'b0;
         clk_out <= 1'b0;
      end else begin
         acc <= ACC_W'(acc_nxt);
         ce  <= wrap;
         if (wrap) begin
            clk_out <= ~clk_out;
         end
      end
   end

endmodule

// File: rtl/clk_enable_gen.sv
// Multi-channel clock-enable generator: config handshake, validation and sync fan-out.
module clk_enable_gen
   import clk_enable_gen_pkg::*;
#(
   parameter int CHANNELS = CHANNELS_DEFAULT,
   parameter int ACC_W    = ACC_W_DEFAULT,
   parameter int DEF_INC  = DEF_INC_DEFAULT,
   parameter int DEF_MOD  = DEF_MOD_DEFAULT
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        sync,
   input  logic                        cfg_valid,
   output logic                        cfg_ready,
   input  logic [idx_w(CHANNELS)-1:0]  cfg_ch,
   input  logic [ACC_W-1:0]            cfg_inc,
   input  logic [ACC_W-1:0]            cfg_mod,
   output logic                        cfg_err,
   output logic [CHANNELS-1:0]         ce,
   output logic [CHANNELS-1:0]         clk_out
);

   localparam int             IDX_W  = idx_w(CHANNELS);
   localparam logic [IDX_W:0] CH_LIM = (IDX_W + 1)'(CHANNELS);

   logic                busy_q;
   logic                err_q;
   logic                accept;
   logic                cfg_ok;
   logic [CHANNELS-1:0] load;

   // Ready is combinational on rst so it rises in the very first cycle out of reset.
   assign cfg_ready = !rst && !busy_q;
   assign accept    = cfg_valid && cfg_ready;
   assign cfg_ok    = (cfg_mod != '0) && (cfg_inc <= cfg_mod) && ({1'b0, cfg_ch} < CH_LIM);
   assign cfg_err   = err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         busy_q <= accept;
         err_q  <= accept && !cfg_ok;
      end
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      assign load[i] = accept && cfg_ok && (cfg_ch == IDX_W'(i));

      clk_enable_chan #(
         .ACC_W   (ACC_W),
         .DEF_INC (DEF_INC),
         .DEF_MOD (DEF_MOD)
      ) u_chan (
         .clk     (clk),
         .rst     (rst),
         .load    (load[i]),
         .restart (sync),
         .cfg_inc (cfg_inc),
         .cfg_mod (cfg_mod),
         .ce      (ce[i]),
         .clk_out (clk_out[i])
      );
   end

endmodule

// File: tb/tb_clk_enable_gen.sv
// Directed table-driven bench for clk_enable_gen (2 channels, 16-bit accumulators).
module tb_clk_enable_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        sync;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [0:0]  cfg_ch;
   logic [15:0] cfg_inc;
   logic [15:0] cfg_mod;
   logic        cfg_err;
   logic [1:0]  ce;
   logic [1:0]  clk_out;

   int n_chk = 0;
   int n_err = 0;

   clk_enable_gen #(
      .CHANNELS (2),
      .ACC_W    (16),
      .DEF_INC  (1),
      .DEF_MOD  (5)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .sync      (sync),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_ch    (cfg_ch),
      .cfg_inc   (cfg_inc),
      .cfg_mod   (cfg_mod),
      .cfg_err   (cfg_err),
      .ce        (ce),
      .clk_out   (clk_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        sync;
      logic        valid;
      logic        ch;
      logic [15:0] inc;
      logic [15:0] mod;
      logic [1:0]  ce;
      logic [1:0]  co;
      logic        rdy;
      logic        err;
   } vec_t;

   vec_t vq[$];

   task automatic av(input logic s, input logic v, input logic ch,
                     input logic [15:0] i, input logic [15:0] m,
                     input logic [1:0] e_ce, input logic [1:0] e_co,
                     input logic e_rdy, input logic e_err);
      vec_t t;
      t.sync = s;  t.valid = v;  t.ch = ch;  t.inc = i;  t.mod = m;
      t.ce = e_ce; t.co = e_co;  t.rdy = e_rdy; t.err = e_err;
      vq.push_back(t);
   endtask

   // Idle cycle shorthand: only the outputs are specified.
   task automatic ai(input logic [1:0] e_ce, input logic [1:0] e_co);
      av(1'b0, 1'b0, 1'b0, 16'd0, 16'd0, e_ce, e_co, 1'b1, 1'b0);
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic s, input logic v, input logic ch,
                        input logic [15:0] i, input logic [15:0] m);
      sync = s; cfg_valid = v; cfg_ch = ch; cfg_inc = i; cfg_mod = m;
   endtask

   int cnt0;
   int cnt1;

   initial begin
      // Defaults inc=1 mod=5 on both channels after reset release.
      for (int k = 0; k < 4; k++) ai(2'b00, 2'b00);
      ai(2'b11, 2'b11);
      for (int k = 0; k < 4; k++) ai(2'b00, 2'b11);
      ai(2'b11, 2'b00);
      // ch1 <- inc=2 mod=5; ch0 keeps counting.
      av(0, 1, 1, 16'd2, 16'd5, 2'b00, 2'b00, 0, 0);
      ai(2'b00, 2'b00);
      ai(2'b00, 2'b00);
      ai(2'b10, 2'b10);
      ai(2'b01, 2'b11);
      ai(2'b10, 2'b01);
      ai(2'b00, 2'b01);
      ai(2'b00, 2'b01);
      ai(2'b10, 2'b11);
      ai(2'b01, 2'b10);
      ai(2'b10, 2'b00);
      // Rejected writes: inc > mod, then mod = 0.
      av(0, 1, 0, 16'd6, 16'd5, 2'b00, 2'b00, 0, 1);
      ai(2'b00, 2'b00);
      av(0, 1, 1, 16'd0, 16'd0, 2'b10, 2'b10, 0, 1);
      ai(2'b01, 2'b11);
      // ch0 <- 1/3, a write offered while not ready is ignored, then ch1 <- 1/4.
      av(0, 1, 0, 16'd1, 16'd3, 2'b10, 2'b00, 0, 0);
      av(0, 1, 1, 16'd1, 16'd4, 2'b00, 2'b00, 1, 0);
      av(0, 1, 1, 16'd1, 16'd4, 2'b00, 2'b00, 0, 0);
      // sync: one all-zero cycle, then pulses 3 and 4 cycles later.
      av(1, 0, 0, 16'd0, 16'd0, 2'b00, 2'b00, 1, 0);
      ai(2'b00, 2'b00);
      ai(2'b00, 2'b00);
      ai(2'b01, 2'b01);
      ai(2'b10, 2'b11);
      // sync together with a valid write to ch0 (1/5).
      av(1, 1, 0, 16'd1, 16'd5, 2'b00, 2'b00, 0, 0);
      ai(2'b00, 2'b00);
      ai(2'b00, 2'b00);
      ai(2'b00, 2'b00);
      ai(2'b10, 2'b10);
      ai(2'b01, 2'b11);
      // inc = 0 disables ch1.
      av(0, 1, 1, 16'd0, 16'd4, 2'b00, 2'b01, 0, 0);
      ai(2'b00, 2'b01);
      ai(2'b00, 2'b01);
      ai(2'b00, 2'b01);
      ai(2'b01, 2'b00);
      ai(2'b00, 2'b00);

      drive(0, 0, 0, 16'd0, 16'd0);
      rst = 1'b1;
      #1;
      check("ready_in_rst_comb", int'(cfg_ready), 0);
      for (int k = 0; k < 3; k++) step();
      check("rst_ce", int'(ce), 0);
      check("rst_clk_out", int'(clk_out), 0);
      check("rst_err", int'(cfg_err), 0);
      check("rst_ready", int'(cfg_ready), 0);
      rst = 1'b0;
      #1;
      check("ready_first_cycle", int'(cfg_ready), 1);

      for (int v = 0; v < vq.size(); v++) begin
         drive(vq[v].sync, vq[v].valid, vq[v].ch, vq[v].inc, vq[v].mod);
         step();
         check($sformatf("v%0d_ce", v), int'(ce), int'(vq[v].ce));
         check($sformatf("v%0d_clk_out", v), int'(clk_out), int'(vq[v].co));
         check($sformatf("v%0d_ready", v), int'(cfg_ready), int'(vq[v].rdy));
         check($sformatf("v%0d_err", v), int'(cfg_err), int'(vq[v].err));
      end

      // Exact long-run rate: 3579/17857 over one full modulus period.
      drive(0, 1, 0, 16'd3579, 16'd17857);
      step();
      check("rate_load_ready", int'(cfg_ready), 0);
      drive(0, 0, 0, 16'd0, 16'd0);
      cnt0 = 0;
      cnt1 = 0;
      for (int k = 0; k < 17857; k++) begin
         step();
         cnt0 += int'(ce[0]);
         cnt1 += int'(ce[1]);
      end
      check("rate_ch0_pulses", cnt0, 3579);
      check("disabled_ch1_pulses", cnt1, 0);

      // Reset mid-operation with a pending error and a write held on the bus.
      drive(0, 1, 0, 16'd6, 16'd5);
      step();
      check("pre_rst_err", int'(cfg_err), 1);
      drive(0, 1, 1, 16'd2, 16'd5);
      rst = 1'b1;
      #1;
      check("mid_rst_ready_comb", int'(cfg_ready), 0);
      for (int k = 0; k < 2; k++) begin
         step();
         check($sformatf("mid_rst%0d_ce", k), int'(ce), 0);
         check($sformatf("mid_rst%0d_clk_out", k), int'(clk_out), 0);
         check($sformatf("mid_rst%0d_err", k), int'(cfg_err), 0);
         check($sformatf("mid_rst%0d_ready", k), int'(cfg_ready), 0);
      end
      drive(0, 0, 0, 16'd0, 16'd0);
      rst = 1'b0;
      #1;
      check("post_rst_ready", int'(cfg_ready), 1);
      for (int k = 1; k <= 10; k++) begin
         step();
         check($sformatf("post_rst_c%0d_ce", k), int'(ce), (k == 5 || k == 10) ? 3 : 0);
         check($sformatf("post_rst_c%0d_clk_out", k), int'(clk_out), (k >= 5 && k < 10) ? 3 : 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end

endmodule
